// File: rtl/imem_arb_pkg.sv
`default_nettype none
// ============================================================================
// imem_arb_pkg : shared types for the program-memory arbiter
// Rev 1.0
// ============================================================================
package imem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_HOST = 2'd1,
    ARB_CPU  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_CPU  = 1'b1
  } arb_owner_e;

endpackage
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// imem_arbiter : round-robin, burst-bounded sharing of the single-ported
//                program memory between host port and instruction fetch
// Rev 1.0
// ============================================================================
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int INSTR_LEN = 20,
  parameter int ADDR      = 5,
  parameter int MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR-1:0]      host_addr,
  input  logic [INSTR_LEN-1:0] host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [INSTR_LEN-1:0] host_rdata,
  input  logic                 cpu_req,
  input  logic [ADDR-1:0]      cpu_addr,
  output logic                 cpu_gnt,
  output logic                 cpu_rvalid,
  output logic [INSTR_LEN-1:0] cpu_rdata,
  output logic                 mem_wr_en,
  output logic [ADDR-1:0]      mem_wr_addr,
  output logic [INSTR_LEN-1:0] mem_wr_data,
  output logic                 mem_rd_en,
  output logic [ADDR-1:0]      mem_rd_addr,
  input  logic [INSTR_LEN-1:0] mem_rd_data
);

  localparam logic [7:0] c_burst_last = 8'(MAX_BURST - 1);

  arb_state_e state_q, state_d;
  arb_owner_e last_owner_q, last_owner_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       host_rvalid_q, host_rvalid_d;
  logic       cpu_rvalid_q, cpu_rvalid_d;
  logic       w_host_rd;
  logic       w_contested_gnt;

  always_comb begin
    host_gnt  = (state_q == ARB_HOST) && host_req;
    cpu_gnt   = (state_q == ARB_CPU) && cpu_req;
    w_host_rd = host_gnt && !host_we;

    mem_wr_en   = host_gnt && host_we;
    mem_rd_en   = w_host_rd || cpu_gnt;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    mem_rd_addr = '0;
    if (mem_wr_en) begin
      mem_wr_addr = host_addr;
      mem_wr_data = host_wdata;
    end
    if (w_host_rd) begin
      mem_rd_addr = host_addr;
    end else if (cpu_gnt) begin
      mem_rd_addr = cpu_addr;
    end

    host_rvalid = host_rvalid_q;
    cpu_rvalid  = cpu_rvalid_q;
    host_rdata  = host_rvalid_q ? mem_rd_data : '0;
    cpu_rdata   = cpu_rvalid_q ? mem_rd_data : '0;

    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (host_req && cpu_req) begin
          state_d = (last_owner_q == OWN_CPU) ? ARB_HOST : ARB_CPU;
        end else if (host_req) begin
          state_d = ARB_HOST;
        end else if (cpu_req) begin
          state_d = ARB_CPU;
        end
      end
      ARB_HOST: begin
        if (!host_req) begin
          state_d = cpu_req ? ARB_CPU : ARB_IDLE;
        end else if (cpu_req && (burst_cnt_q == c_burst_last)) begin
          state_d = ARB_CPU;
        end
      end
      ARB_CPU: begin
        if (!cpu_req) begin
          state_d = host_req ? ARB_HOST : ARB_IDLE;
        end else if (host_req && (burst_cnt_q == c_burst_last)) begin
          state_d = ARB_HOST;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // The burst only counts while contested; an uncontested owner never yields.
    w_contested_gnt = (host_gnt && cpu_req) || (cpu_gnt && host_req);
    if (state_d != state_q) begin
      burst_cnt_d = '0;
    end else if (w_contested_gnt) begin
      burst_cnt_d = burst_cnt_q + 8'd1;
    end else begin
      burst_cnt_d = '0;
    end

    last_owner_d = last_owner_q;
    if (host_gnt) begin
      last_owner_d = OWN_HOST;
    end else if (cpu_gnt) begin
      last_owner_d = OWN_CPU;
    end

    host_rvalid_d = w_host_rd;
    cpu_rvalid_d  = cpu_gnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ARB_IDLE;
      last_owner_q  <= OWN_CPU;
      burst_cnt_q   <= '0;
      host_rvalid_q <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_owner_q  <= last_owner_d;
      burst_cnt_q   <= burst_cnt_d;
      host_rvalid_q <= host_rvalid_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_imem_arbiter : randomized and directed checks of imem_arbiter against a
//                   behavioural ownership/memory model
// Rev 1.0
// ============================================================================
module tb_imem_arbiter;
  import imem_arb_pkg::*;

  localparam int IL = 20;
  localparam int AW = 5;
  localparam int MB = 2;

  logic          clk;
  logic          rst;
  logic          host_req, host_we, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [IL-1:0] host_wdata, host_rdata;
  logic          cpu_req, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [IL-1:0] cpu_rdata;
  logic          mem_wr_en, mem_rd_en;
  logic [AW-1:0] mem_wr_addr, mem_rd_addr;
  logic [IL-1:0] mem_wr_data, mem_rd_data;

  imem_arbiter #(.INSTR_LEN(IL), .ADDR(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(rst),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-ported memory with registered read
  logic [IL-1:0] mem [32];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Reference model: who owns the port (0 none, 1 host, 2 cpu), who was last
  // served, and how many contested grants the current owner has had.
  int            m_own, m_last, m_streak;
  bit            m_hrv, m_crv;
  logic [IL-1:0] m_hrd, m_crd;
  logic [IL-1:0] m_mem [32];
  logic [IL-1:0] pre [32];

  bit            obs_hg, obs_cg, obs_hrv, obs_crv, obs_wr;
  logic [IL-1:0] obs_hrd, obs_crd;

  task automatic model_reset();
    m_own = 0; m_last = 2; m_streak = 0; m_hrv = 0; m_crv = 0;
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic tick();
    bit e_hg, e_cg, e_wr, e_hrd, hreq, creq, mine, theirs;
    logic [AW-1:0] e_raddr;
    arb_state_e e_state;
    int nxt, other;
    #2;
    e_hg    = (m_own == 1) && host_req;
    e_cg    = (m_own == 2) && cpu_req;
    e_wr    = e_hg && host_we;
    e_hrd   = e_hg && !host_we;
    e_raddr = e_hrd ? host_addr : (e_cg ? cpu_addr : '0);
    e_state = (m_own == 1) ? ARB_HOST : ((m_own == 2) ? ARB_CPU : ARB_IDLE);
    obs_hg = host_gnt; obs_cg = cpu_gnt; obs_wr = mem_wr_en;
    obs_hrv = host_rvalid; obs_crv = cpu_rvalid;
    obs_hrd = host_rdata; obs_crd = cpu_rdata;
    check_eq("host_gnt", 32'(host_gnt), 32'(e_hg));
    check_eq("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
    check_eq("mem_wr_en", 32'(mem_wr_en), 32'(e_wr));
    check_eq("mem_rd_en", 32'(mem_rd_en), 32'(e_hrd || e_cg));
    check_eq("mem_rd_addr", 32'(mem_rd_addr), 32'(e_raddr));
    check_eq("mem_wr_addr", 32'(mem_wr_addr), e_wr ? 32'(host_addr) : 32'd0);
    check_eq("mem_wr_data", 32'(mem_wr_data), e_wr ? 32'(host_wdata) : 32'd0);
    check_eq("host_rvalid", 32'(host_rvalid), 32'(m_hrv));
    check_eq("host_rdata", 32'(host_rdata), m_hrv ? 32'(m_hrd) : 32'd0);
    check_eq("cpu_rvalid", 32'(cpu_rvalid), 32'(m_crv));
    check_eq("cpu_rdata", 32'(cpu_rdata), m_crv ? 32'(m_crd) : 32'd0);
    check_eq("state", 32'(dut.state_q), 32'(e_state));
    check_eq("burst_cnt", 32'(dut.burst_cnt_q), 32'(m_streak));
    @(posedge clk);
    hreq = host_req; creq = cpu_req;
    m_hrv = e_hrd;
    if (e_hrd) m_hrd = m_mem[host_addr];
    m_crv = e_cg;
    if (e_cg) m_crd = m_mem[cpu_addr];
    if (e_wr) m_mem[host_addr] = host_wdata;
    if (e_hg) m_last = 1;
    if (e_cg) m_last = 2;
    theirs = 0;
    if (m_own == 0) begin
      if (hreq && creq) nxt = (m_last == 2) ? 1 : 2;
      else if (hreq) nxt = 1;
      else if (creq) nxt = 2;
      else nxt = 0;
    end else begin
      mine   = (m_own == 1) ? hreq : creq;
      theirs = (m_own == 1) ? creq : hreq;
      other  = 3 - m_own;
      if (!mine) nxt = theirs ? other : 0;
      else if (theirs && (m_streak + 1 >= MB)) nxt = other;
      else nxt = m_own;
    end
    m_streak = ((nxt == m_own) && (e_hg || e_cg) && theirs) ? m_streak + 1 : 0;
    m_own = nxt;
    #1;
  endtask

  task automatic check_outputs_clear(input string tag);
    check_eq({tag, "_gnts"}, 32'({host_gnt, cpu_gnt}), 32'd0);
    check_eq({tag, "_mem_en"}, 32'({mem_wr_en, mem_rd_en}), 32'd0);
    check_eq({tag, "_rvalids"}, 32'({host_rvalid, cpu_rvalid}), 32'd0);
    check_eq({tag, "_rdata"}, 32'(host_rdata | cpu_rdata), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; host_req = 1'b0; cpu_req = 1'b0;
    #1;
    check_outputs_clear("async_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic host_access(input bit we, input logic [AW-1:0] a, input logic [IL-1:0] d);
    int n;
    n = 0;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    do begin
      tick(); n++;
    end while (!obs_hg && n < 20);
    if (!obs_hg) check_eq("host_access_timeout", 32'd0, 32'd1);
  endtask

  task automatic host_read(input logic [AW-1:0] a, output logic [IL-1:0] d, output bit rv);
    host_access(1'b0, a, '0);
    host_req = 1'b0;
    tick();
    d = obs_hrd; rv = obs_hrv;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pat [6];
    int ncg, idx, wait_c, t, nwr;
    bit cpu_seen, rv;
    logic [IL-1:0] rd;
    logic [IL-1:0] w4 [10];

    rst = 1'b1; host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    cpu_req = 0; cpu_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_clear("reset_values");
    rst = 1'b0;
    #1;
    check_eq("reset_state", 32'(dut.state_q), 32'(ARB_IDLE));
    check_eq("reset_burst", 32'(dut.burst_cnt_q), 32'd0);
    @(posedge clk); #1;

    // Write then read address 3
    host_req = 1; host_we = 1; host_addr = 5'd3; host_wdata = 20'hABCDE;
    tick(); check_eq("s1_idle_no_gnt", 32'(obs_hg), 32'd0);
    tick(); check_eq("s1_wr_gnt", 32'(obs_hg), 32'd1);
    host_we = 0;
    tick(); check_eq("s1_rd_gnt", 32'(obs_hg), 32'd1);
    host_req = 0;
    tick();
    check_eq("s1_rvalid", 32'(obs_hrv), 32'd1);
    check_eq("s1_rdata", 32'(obs_hrd), 32'hABCDE);

    // Preload every word so later reads have a defined reference
    for (int i = 0; i < 32; i++) begin
      pre[i] = IL'($urandom);
      host_access(1'b1, AW'(i), pre[i]);
    end
    host_req = 0;
    tick();

    // Simultaneous requests after reset: host first, then bursts of MB
    do_reset();
    pat = '{1, 1, 2, 2, 1, 1};
    host_req = 1; cpu_req = 1; host_we = 0; host_addr = 5'd7; cpu_addr = 5'd9;
    tick(); check_eq("s2_idle_no_gnt", 32'({obs_hg, obs_cg}), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq("s2_pattern", obs_hg ? 32'd1 : (obs_cg ? 32'd2 : 32'd0), 32'(pat[k]));
    end
    host_req = 0; cpu_req = 0;
    tick(); tick();

    // Uncontested fetch stream
    cpu_req = 1; cpu_addr = '0;
    tick();
    ncg = 0;
    for (int i = 0; i <= 20; i++) begin
      cpu_req  = (i < 20);
      cpu_addr = (i < 20) ? AW'(i) : '0;
      tick();
      if (obs_cg) ncg++;
      if (i > 0) check_eq("s3_fetch_data", 32'(obs_crd), 32'(pre[i-1]));
    end
    check_eq("s3_gnt_count", 32'(ncg), 32'd20);

    // Host write burst, CPU joins part-way
    for (int i = 0; i < 10; i++) w4[i] = IL'($urandom);
    idx = 0; wait_c = 0; t = 0; nwr = 0; cpu_seen = 0;
    host_req = 1; host_we = 1; host_addr = 5'd20; host_wdata = w4[0];
    while (idx < 10 && t < 100) begin
      if (idx >= 2 && !cpu_seen && !cpu_req) begin
        cpu_req = 1; cpu_addr = 5'd1;
      end
      tick(); t++;
      if (obs_wr) nwr++;
      if (cpu_req && !cpu_seen) begin
        wait_c++;
        if (obs_cg) cpu_seen = 1;
      end
      if (obs_hg) begin
        idx++;
        if (idx < 10) begin
          host_addr = AW'(20 + idx); host_wdata = w4[idx];
        end
      end
    end
    host_req = 0; cpu_req = 0;
    tick();
    check_eq("s4_cpu_granted", 32'(cpu_seen), 32'd1);
    check_eq("s4_wait_bound", 32'(wait_c <= MB + 1), 32'd1);
    check_eq("s4_write_count", 32'(nwr), 32'd10);
    for (int i = 0; i < 10; i++) begin
      host_read(AW'(20 + i), rd, rv);
      check_eq("s4_readback_valid", 32'(rv), 32'd1);
      check_eq("s4_readback_data", 32'(rd), 32'(w4[i]));
    end

    // Reset while a fetch is in flight
    do_reset();
    cpu_req = 1; cpu_addr = 5'd5;
    tick();
    #2;
    check_eq("s5_gnt_before_reset", 32'(cpu_gnt), 32'd1);
    rst = 1; cpu_req = 0;
    #1;
    check_eq("s5_gnt_cleared", 32'(cpu_gnt), 32'd0);
    check_eq("s5_rd_en_cleared", 32'(mem_rd_en), 32'd0);
    @(posedge clk); #1;
    check_eq("s5_rvalid_in_reset", 32'(cpu_rvalid), 32'd0);
    rst = 0;
    #1;
    check_eq("s5_rvalid_after", 32'(cpu_rvalid), 32'd0);
    check_eq("s5_state_idle", 32'(dut.state_q), 32'(ARB_IDLE));
    model_reset();
    @(posedge clk); #1;
    host_req = 1; cpu_req = 1; host_we = 0; host_addr = 5'd2; cpu_addr = 5'd6;
    tick(); tick();
    check_eq("s5_tie_to_host", 32'(obs_hg), 32'd1);
    host_req = 0; cpu_req = 0;
    tick(); tick();

    // Host drops request mid-burst with CPU idle
    host_req = 1; host_we = 0; host_addr = 5'd4;
    repeat (4) tick();
    host_req = 0;
    tick();
    check_eq("s6_state_idle", 32'(dut.state_q), 32'(ARB_IDLE));
    check_eq("s6_burst_zero", 32'(dut.burst_cnt_q), 32'd0);
    tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      host_req   = ($urandom_range(0, 99) < 60);
      host_we    = $urandom_range(0, 1) == 1;
      host_addr  = AW'($urandom);
      host_wdata = IL'($urandom);
      cpu_req    = ($urandom_range(0, 99) < 60);
      cpu_addr   = AW'($urandom);
      tick();
    end
    host_req = 0; cpu_req = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter that shares the single-ported program memory between the host preload/readback port and the controller's instruction-fetch port. Sits between `memory` and its two users inside `top`, replacing the hardwired `rd_en = 1` / `rd_addr = pc` connection. At most one memory access is issued per cycle. Ownership is round-robin with a bounded burst so neither side starves.

## Interface
Parameters:
- `INSTR_LEN`, 20: memory word width.
- `ADDR`, 5: memory address width.
- `MAX_BURST`, 8: maximum consecutive grants to one owner while the other side is requesting; legal range is 1 to 255.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `host_req`  in  1  host requests an access this cycle.
- `host_we`  in  1  1 = write, 0 = read; qualified by `host_req`.
- `host_addr`  in  ADDR  host address.
- `host_wdata`  in  INSTR_LEN  host write data.
- `host_gnt`  out  1  host access is issued this cycle.
- `host_rvalid`  out  1  `host_rdata` is valid (host read issued one cycle earlier).
- `host_rdata`  out  INSTR_LEN  read data returned to host.
- `cpu_req`  in  1  controller fetch request; fetch is read-only.
- `cpu_addr`  in  ADDR  fetch address (pc).
- `cpu_gnt`  out  1  fetch is issued this cycle.
- `cpu_rvalid`  out  1  `cpu_rdata` is valid.
- `cpu_rdata`  out  INSTR_LEN  instruction returned to controller.
- `mem_wr_en`, `mem_wr_addr`, `mem_wr_data`  out  1 / ADDR / INSTR_LEN  memory write port.
- `mem_rd_en`, `mem_rd_addr`  out  1 / ADDR  memory read port.
- `mem_rd_data`  in  INSTR_LEN  memory read data; registered, valid one cycle after `mem_rd_en`.

## Operation
- The FSM state register is one of IDLE, HOST, or CPU. Two further registers exist:
  - `last_owner`: reset value CPU, so the host wins the first tie.
  - `burst_cnt`: 8 bits, reset value 0.
- Grants are combinational from the registered state:
  - `host_gnt = (state==HOST) & host_req`
  - `cpu_gnt = (state==CPU) & cpu_req`
- Memory drive:
  - `mem_wr_en = host_gnt & host_we`
  - `mem_rd_en = (host_gnt & ~host_we) | cpu_gnt`
  - Address and data are muxed from the granted side. With no grant, the memory outputs are 0.
- Transitions from IDLE:
  - Only one side requesting: go to that side's state.
  - Both requesting: go to the side that is not `last_owner`.
  - Neither requesting: stay in IDLE.
- Transitions from HOST or CPU:
  - Owner's req low: go to the other side's state if it is requesting, else IDLE.
  - Owner's req high, other side requesting, and `burst_cnt == MAX_BURST-1`: forced yield to the other side.
  - Otherwise: stay.
- `burst_cnt` behaviour:
  - Increments on each grant while the other side is requesting.
  - Clears on any state change.
  - Clears while the other side is idle, so a burst is unlimited when uncontested.
- `last_owner` updates on every grant.
- Read return:
  - `host_rvalid` and `cpu_rvalid` are registered copies of the respective read grant.
  - `host_rdata = host_rvalid ? mem_rd_data : 0`; `cpu_rdata` is formed the same way.
- Host writes never produce `rvalid`.
- Host write-then-read to the same address in consecutive grants returns the new data.

## Timing
- Reset values:
  - State IDLE and `burst_cnt` 0.
  - All gnt and rvalid outputs are 0, all rdata outputs are 0, and all `mem_*` enables are 0.
- Request to first grant:
  - 1 cycle from IDLE.
  - 0 cycles if the state already belongs to the requester.
- Grant to read data: 1 cycle. A requester may hold req continuously and receive one access per cycle.
- Worst-case wait with the other side continuously requesting: MAX_BURST+1 cycles.
- Simultaneous req rise on both sides from IDLE: the side that is not `last_owner` wins.
- Reset asserted mid-operation:
  - Outputs clear immediately, without waiting for a clock edge.
  - Any in-flight `rvalid` is discarded, not delivered.
  - After reset is released, the first tie goes to the host.
- Address wrap-around is the requester's responsibility; the arbiter passes addresses unchanged.

## Structure
- Package `imem_arb_pkg`:
  - enum `arb_state_e` {ARB_IDLE, ARB_HOST, ARB_CPU}.
  - enum `arb_owner_e` {OWN_HOST, OWN_CPU}.
- Single module with no sub-module. The FSM, burst counter, and rvalid registers fit in one `always_ff`, with one `always_comb` for next state and muxing.

## Test plan
- Reset, then host writes 0xABCDE to address 3, then host reads address 3 → `host_gnt` is 1 in the cycle after req, and `host_rvalid` is 1 with `host_rdata` 0xABCDE one cycle after the read grant.
- Both sides raise req in the same cycle from IDLE after reset → host granted first. With MAX_BURST=2 and both held high, the grant pattern is H,H,C,C,H,H.
- CPU requests alone for 20 cycles at pc 0..19 → 20 back-to-back `cpu_gnt` pulses with no yield. `cpu_rdata` follows the preloaded words with 1-cycle lag.
- Host in a write burst, CPU raises req → CPU granted no later than MAX_BURST+1 cycles after its req, and no host write is lost or duplicated.
- Reset pulsed for 1 cycle while a CPU read is in flight → `cpu_rvalid` stays 0, and the state is IDLE after release.
- Host drops req mid-burst while CPU is idle → state goes to IDLE next cycle and `burst_cnt` reads 0.
